// File: rtl/print_pkg.sv
// Shared definitions for the print-job engine: FSM state encoding and the
// full-tank level helper.
package print_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PRINT = 3'd2,
    ST_STALL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Full tank level for a tank of the given width (all ones).
  function automatic int unsigned ink_full(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/ink_tank.sv
// One ink channel: holds the tank level, refills to full on request and
// drops by one unit when a page consumes from it.
module ink_tank
  import print_pkg::*;
#(
  parameter int INK_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                refill,
  input  logic                consume,
  output logic [INK_BITS-1:0] level,
  output logic                empty
);

  localparam logic [INK_BITS-1:0] INK_FULL = INK_BITS'(ink_full(INK_BITS));

  logic [INK_BITS-1:0] level_q;
  logic [INK_BITS-1:0] level_d;

  // Next level: refill wins over consume; never wraps below zero.
  always_comb begin
    level_d = level_q;
    if (refill) begin
      level_d = INK_FULL;
    end else if (consume && (level_q != '0)) begin
      level_d = level_q - INK_BITS'(1);
    end
  end

  // Level register, reset to a full tank.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= INK_FULL;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign empty = (level_q == '0);

endmodule

// File: rtl/print_job_engine.sv
// Print-job controller. Accepts a job (page count + ink mask) over a
// valid/ready handshake and walks it page by page: CHECK reserves one unit of
// every selected ink, PRINT spends PAGE_CYCLES cycles on the page, STALL waits
// for empty selected tanks to be refilled.
//
// Handshake: a job transfers on a rising edge where job_valid and job_ready
// are both high; job_pages/job_mask are captured on that edge. job_ready
// depends only on state and prendido, never on job_valid.
module print_job_engine
  import print_pkg::*;
#(
  parameter int NUM_INKS    = 4,
  parameter int INK_BITS    = 4,
  parameter int PAGE_BITS   = 3,
  parameter int PAGE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prendido,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [PAGE_BITS-1:0]         job_pages,
  input  logic [NUM_INKS-1:0]          job_mask,
  input  logic                         abort,
  input  logic [NUM_INKS-1:0]          refill,
  output logic                         printing,
  output logic                         stalled,
  output logic                         page_done,
  output logic                         job_done,
  output logic [PAGE_BITS-1:0]         pages_left,
  output logic [NUM_INKS-1:0]          ink_empty,
  output logic [NUM_INKS*INK_BITS-1:0] ink_level,
  output logic [2:0]                   state_dbg
);

  localparam int CNT_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAGE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAGE_BITS-1:0] pages_q, pages_d;
  logic [NUM_INKS-1:0]  mask_q, mask_d;
  logic [NUM_INKS-1:0]  consume;
  logic                 masked_empty;
  logic                 stall_clear;

  // A selected tank is empty right now.
  assign masked_empty = |(mask_q & ink_empty);
  // Every selected tank is nonzero or being refilled on this edge, so the
  // stall can be left without waiting a cycle for the new level to show.
  assign stall_clear  = ((mask_q & ink_empty & ~refill) == '0);

  // State register plus job datapath (page count, cycle counter, mask).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pages_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pages_q <= pages_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state and datapath update: abort beats the power freeze.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pages_d = pages_q;
    mask_d  = mask_q;
    consume = '0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pages_d = '0;
      cnt_d   = '0;
    end else if (prendido) begin
      case (state_q)
        ST_IDLE: begin
          if (job_valid) begin
            mask_d  = job_mask;
            pages_d = job_pages;
            if ((job_pages == '0) || (job_mask == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (masked_empty) begin
            state_d = ST_STALL;
          end else begin
            consume = mask_q;
            cnt_d   = CNT_LOAD;
            state_d = ST_PRINT;
          end
        end
        ST_PRINT: begin
          if (cnt_q == '0) begin
            pages_d = pages_q - PAGE_BITS'(1);
            state_d = (pages_q == PAGE_BITS'(1)) ? ST_DONE : ST_CHECK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_STALL: begin
          if (stall_clear) begin
            state_d = ST_CHECK;
          end
        end
        ST_DONE: begin
          pages_d = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the (possibly frozen) state.
  always_comb begin
    job_ready  = (state_q == ST_IDLE) && prendido;
    printing   = (state_q == ST_PRINT);
    stalled    = (state_q == ST_STALL);
    page_done  = (state_q == ST_PRINT) && (cnt_q == '0);
    job_done   = (state_q == ST_DONE);
    pages_left = pages_q;
    state_dbg  = state_q;
  end

  for (genvar i = 0; i < NUM_INKS; i++) begin : g_tank
    ink_tank #(
      .INK_BITS(INK_BITS)
    ) u_tank (
      .clk    (clk),
      .reset  (reset),
      .refill (refill[i]),
      .consume(consume[i]),
      .level  (ink_level[i*INK_BITS +: INK_BITS]),
      .empty  (ink_empty[i])
    );
  end

endmodule

// File: tb/tb_print_job_engine.sv
// Directed bench for print_job_engine with default parameters.
module tb_print_job_engine;
  import print_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        prendido;
  logic        job_valid;
  logic        job_ready;
  logic [2:0]  job_pages;
  logic [3:0]  job_mask;
  logic        abort;
  logic [3:0]  refill;
  logic        printing;
  logic        stalled;
  logic        page_done;
  logic        job_done;
  logic [2:0]  pages_left;
  logic [3:0]  ink_empty;
  logic [15:0] ink_level;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  print_job_engine dut (
    .clk       (clk),
    .reset     (reset),
    .prendido  (prendido),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_pages (job_pages),
    .job_mask  (job_mask),
    .abort     (abort),
    .refill    (refill),
    .printing  (printing),
    .stalled   (stalled),
    .page_done (page_done),
    .job_done  (job_done),
    .pages_left(pages_left),
    .ink_empty (ink_empty),
    .ink_level (ink_level),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Drivers and checkers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [2:0] pages, input logic [3:0] mask);
    job_valid = 1'b1;
    job_pages = pages;
    job_mask  = mask;
    tick();
    job_valid = 1'b0;
  endtask

  // Called in cycle T+1 (cyc=1); returns the cycle index where job_done is seen.
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 1;
    while (!job_done && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    reset = 1'b1; prendido = 1'b1; job_valid = 1'b0; job_pages = '0;
    job_mask = '0; abort = 1'b0; refill = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_levels", ink_level, 16'hFFFF);
    chk("rst_pages", pages_left, 0);
    chk("rst_outs", {printing, stalled, page_done, job_done}, 4'b0000);
    chk("rst_empty", ink_empty, 4'b0000);
    chk("rst_ready", job_ready, 1);

    // Basic job: 3 pages on ink0
    start_job(3'd3, 4'b0001);
    chk("basic_check_state", state_dbg, ST_CHECK);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("basic_page_done_c%0d", c), page_done, (c == 5 || c == 10 || c == 15));
      chk($sformatf("basic_job_done_c%0d", c), job_done, (c == 16));
      if (c == 2) chk("basic_printing", printing, 1);
      if (c < 16) tick();
    end
    chk("basic_levels", ink_level, 16'hFFFC);
    tick();
    chk("basic_idle", state_dbg, ST_IDLE);

    // Drain ink1 to 1 with two 7-page jobs
    for (int j = 0; j < 2; j++) begin
      start_job(3'd7, 4'b0010);
      wait_done(60, cyc);
      chk("drain_done", job_done, 1);
      chk("drain_latency", cyc, 36);
      tick();
    end
    chk("drain_levels", ink_level, 16'hFF1C);

    // Stall: 2 pages on ink1, second page runs dry
    start_job(3'd2, 4'b0010);
    cyc = 1;
    while (!stalled && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("stall_seen", stalled, 1);
    chk("stall_cycle", cyc, 7);
    chk("stall_level", ink_level, 16'hFF0C);
    chk("stall_empty", ink_empty, 4'b0010);
    tick(); tick();
    chk("stall_hold", stalled, 1);
    refill = 4'b0010;
    tick();
    refill = 4'b0000;
    chk("stall_r1_state", state_dbg, ST_CHECK);
    chk("stall_r1_level", ink_level, 16'hFFFC);
    tick();
    chk("stall_r2_print", printing, 1);
    chk("stall_r2_level", ink_level, 16'hFFEC);
    wait_done(20, cyc);
    chk("stall_done", job_done, 1);
    chk("stall_final", ink_level, 16'hFFEC);
    tick();

    // Abort in second PRINT cycle of a 4-page job
    refill = 4'b0001;
    tick();
    refill = 4'b0000;
    chk("abort_prefill", ink_level, 16'hFFEF);
    start_job(3'd4, 4'b0001);
    tick();
    tick();
    chk("abort_in_print", printing, 1);
    chk("abort_pages_pre", pages_left, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", state_dbg, ST_IDLE);
    chk("abort_pages", pages_left, 0);
    chk("abort_no_done", job_done, 0);
    chk("abort_level", ink_level, 16'hFFEE);
    tick();
    chk("abort_still_idle", state_dbg, ST_IDLE);
    chk("abort_no_done2", job_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_idle_ignored", state_dbg, ST_IDLE);

    // Refill collides with CHECK decrement on ink0
    start_job(3'd1, 4'b0001);
    chk("coll_check", state_dbg, ST_CHECK);
    refill = 4'b0001;
    tick();
    refill = 4'b0000;
    chk("coll_level", ink_level, 16'hFFEF);
    wait_done(20, cyc);
    chk("coll_done", job_done, 1);
    tick();

    // Degenerate jobs
    start_job(3'd0, 4'b0001);
    chk("zero_pages_done", job_done, 1);
    chk("zero_pages_levels", ink_level, 16'hFFEF);
    tick();
    chk("zero_pages_idle", state_dbg, ST_IDLE);
    start_job(3'd2, 4'b0000);
    chk("zero_mask_done", job_done, 1);
    chk("zero_mask_levels", ink_level, 16'hFFEF);
    tick();
    chk("zero_mask_idle", state_dbg, ST_IDLE);

    // Power freeze for 5 cycles mid-PRINT on a 1-page job
    start_job(3'd1, 4'b0001);
    tick();
    tick();
    prendido = 1'b0;
    for (int f = 0; f < 5; f++) begin
      chk("frz_ready", job_ready, 0);
      chk("frz_printing", printing, 1);
      chk("frz_page_done", page_done, 0);
      chk("frz_pages", pages_left, 1);
      tick();
    end
    prendido = 1'b1;
    for (int c = 8; c <= 11; c++) begin
      chk($sformatf("frz_page_done_c%0d", c), page_done, (c == 10));
      chk($sformatf("frz_job_done_c%0d", c), job_done, (c == 11));
      if (c < 11) tick();
    end
    chk("frz_level", ink_level, 16'hFFEE);
    tick();
    chk("frz_idle_ready", job_ready, 1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
